// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter: FSM states, owner codes
// and the downstream operation encoding.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_D = 2'b01,
        OWN_I = 2'b10
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_D    = 2'b01;
    localparam logic [1:0] OWNER_I    = 2'b10;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // A data-side write enable always takes precedence over a read enable.
    function automatic logic d_op(input logic w_en);
        return w_en ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of requester-side, SRAM-side and status signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 64
);
    logic              d_r_en;
    logic              d_w_en;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_w_data;
    logic              d_ready;
    logic [LINE_W-1:0] d_r_data;

    logic              i_r_en;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [LINE_W-1:0] i_r_data;

    logic              s_r_en;
    logic              s_w_en;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_w_data;
    logic [LINE_W-1:0] s_r_data;
    logic              s_ready;

    logic [1:0]        owner;
    logic              proto_err;

    modport slave (
        input  d_r_en, d_w_en, d_addr, d_w_data, i_r_en, i_addr, s_r_data, s_ready,
        output d_ready, d_r_data, i_ready, i_r_data, s_r_en, s_w_en, s_addr, s_w_data,
               owner, proto_err
    );

    modport master (
        output d_r_en, d_w_en, d_addr, d_w_data, i_r_en, i_addr, s_r_data, s_ready,
        input  d_ready, d_r_data, i_ready, i_r_data, s_r_en, s_w_en, s_addr, s_w_data,
               owner, proto_err
    );
endinterface

// File: rtl/sram_arb_pick.sv
// Winner selection between data and instruction requesters, with a saturating
// counter that forces an instruction grant after too many back-to-back data wins.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic d_r_en,
    input  logic d_w_en,
    input  logic i_r_en,
    output logic grant_d,
    output logic grant_i,
    output logic is_write,
    output logic err
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             d_req;
    logic             force_i;

    always_comb begin
        d_req    = d_r_en | d_w_en;
        force_i  = i_r_en && (starve_cnt == LIMIT);
        grant_d  = arb_en && d_req && !force_i;
        grant_i  = arb_en && i_r_en && (!d_req || force_i);
        is_write = d_op(d_w_en);
        err      = arb_en && d_r_en && d_w_en;
    end

    // Counts data grants taken while the instruction side was waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && i_r_en && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller port between the MEM-stage data side and the IF-stage
// fetch path: grants one owner, latches its request and steers the ready pulse back.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LINE_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arbiter_if.slave   bus
);
    arb_state_t        state, state_next;
    logic              s_r_en_q, s_r_en_next;
    logic              s_w_en_q, s_w_en_next;
    logic [ADDR_W-1:0] s_addr_q, s_addr_next;
    logic [DATA_W-1:0] s_w_data_q, s_w_data_next;
    logic [1:0]        owner_q, owner_next;
    logic              proto_err_q, proto_err_next;

    logic arb_en;
    logic grant_d;
    logic grant_i;
    logic is_write;
    logic pick_err;

    assign arb_en = (state == IDLE);

    sram_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (arb_en),
        .d_r_en   (bus.d_r_en),
        .d_w_en   (bus.d_w_en),
        .i_r_en   (bus.i_r_en),
        .grant_d  (grant_d),
        .grant_i  (grant_i),
        .is_write (is_write),
        .err      (pick_err)
    );

    // Request inputs only reach the s_* registers through this block, never the outputs directly.
    always_comb begin
        state_next     = state;
        s_r_en_next    = s_r_en_q;
        s_w_en_next    = s_w_en_q;
        s_addr_next    = s_addr_q;
        s_w_data_next  = s_w_data_q;
        owner_next     = owner_q;
        proto_err_next = proto_err_q | pick_err;

        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next    = OWN_D;
                    owner_next    = OWNER_D;
                    s_addr_next   = bus.d_addr;
                    s_w_data_next = bus.d_w_data;
                    s_w_en_next   = (is_write == OP_WRITE);
                    s_r_en_next   = (is_write == OP_READ);
                end else if (grant_i) begin
                    state_next  = OWN_I;
                    owner_next  = OWNER_I;
                    s_addr_next = bus.i_addr;
                    s_w_en_next = 1'b0;
                    s_r_en_next = 1'b1;
                end
            end
            OWN_D, OWN_I: begin
                if (bus.s_ready) begin
                    state_next  = IDLE;
                    owner_next  = OWNER_NONE;
                    s_r_en_next = 1'b0;
                    s_w_en_next = 1'b0;
                end
            end
            default: begin
                state_next  = IDLE;
                owner_next  = OWNER_NONE;
                s_r_en_next = 1'b0;
                s_w_en_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            s_r_en_q    <= 1'b0;
            s_w_en_q    <= 1'b0;
            s_addr_q    <= '0;
            s_w_data_q  <= '0;
            owner_q     <= OWNER_NONE;
            proto_err_q <= 1'b0;
        end else begin
            state       <= state_next;
            s_r_en_q    <= s_r_en_next;
            s_w_en_q    <= s_w_en_next;
            s_addr_q    <= s_addr_next;
            s_w_data_q  <= s_w_data_next;
            owner_q     <= owner_next;
            proto_err_q <= proto_err_next;
        end
    end

    // Completion is forwarded in the same cycle; the non-owner never sees a pulse.
    always_comb begin
        bus.d_ready  = (state == OWN_D) && bus.s_ready;
        bus.i_ready  = (state == OWN_I) && bus.s_ready;
        bus.d_r_data = bus.d_ready ? bus.s_r_data : '0;
        bus.i_r_data = bus.i_ready ? bus.s_r_data : '0;
    end

    assign bus.s_r_en    = s_r_en_q;
    assign bus.s_w_en    = s_w_en_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_w_data  = s_w_data_q;
    assign bus.owner     = owner_q;
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized
// transactions checked against a grant-order model driven by the fairness rule.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int LIMIT = 2;

    logic clk;
    logic rst;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LINE_W(64)) bus ();

    sram_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .LINE_W       (64),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks;
    int   errors;
    int   d_streak;
    logic exp_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic dr, input logic dw, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic ir,
                                 input logic [31:0] ia);
        bus.d_r_en   = dr;
        bus.d_w_en   = dw;
        bus.d_addr   = da;
        bus.d_w_data = dwd;
        bus.i_r_en   = ir;
        bus.i_addr   = ia;
    endtask

    // One arbitration from IDLE through completion; the model decides the winner.
    task automatic run_txn(input logic dr, input logic dw, input logic [31:0] da,
                           input logic [31:0] dwd, input logic ir, input logic [31:0] ia,
                           input int lat, input logic [63:0] line);
        logic        win_d;
        logic        win_i;
        logic        wr;
        logic [31:0] exp_addr;
        win_d = 1'b0;
        win_i = 1'b0;
        if (dr || dw || ir) begin
            if (ir && (!(dr || dw) || d_streak >= LIMIT)) begin
                win_i    = 1'b1;
                d_streak = 0;
            end else begin
                win_d = 1'b1;
                if (ir && d_streak < LIMIT) d_streak++;
            end
            if (dr && dw) exp_err = 1'b1;
        end
        wr = win_d && dw;

        applyStimulus(dr, dw, da, dwd, ir, ia);
        cycle();
        if (!win_d && !win_i) begin
            checkOutput("idle_owner", 64'(bus.owner), 64'(0));
            checkOutput("idle_s_r_en", 64'(bus.s_r_en), 64'(0));
            checkOutput("idle_s_w_en", 64'(bus.s_w_en), 64'(0));
            return;
        end

        exp_addr = win_d ? da : ia;
        checkOutput("grant_owner", 64'(bus.owner), win_d ? 64'(1) : 64'(2));
        checkOutput("grant_s_w_en", 64'(bus.s_w_en), 64'(wr));
        checkOutput("grant_s_r_en", 64'(bus.s_r_en), 64'(!wr));
        checkOutput("grant_s_addr", 64'(bus.s_addr), 64'(exp_addr));
        if (wr) checkOutput("grant_s_w_data", 64'(bus.s_w_data), 64'(dwd));
        checkOutput("proto_err", 64'(bus.proto_err), 64'(exp_err));

        for (int k = 0; k < lat; k++) begin
            bus.d_addr   = (k == 0) ? (da ^ 32'h0000_0C00) : $urandom;
            bus.i_addr   = $urandom;
            bus.d_w_data = $urandom;
            bus.d_r_en   = 1'($urandom);
            bus.i_r_en   = 1'($urandom);
            bus.d_w_en   = 1'b0;
            #1;
            checkOutput("wait_d_ready", 64'(bus.d_ready), 64'(0));
            checkOutput("wait_i_ready", 64'(bus.i_ready), 64'(0));
            checkOutput("hold_s_addr", 64'(bus.s_addr), 64'(exp_addr));
            cycle();
        end

        bus.s_ready  = 1'b1;
        bus.s_r_data = line;
        #1;
        checkOutput("done_d_ready", 64'(bus.d_ready), 64'(win_d));
        checkOutput("done_i_ready", 64'(bus.i_ready), 64'(win_i));
        if (win_d && !wr) checkOutput("done_d_r_data", bus.d_r_data, line);
        if (win_i) checkOutput("done_i_r_data", bus.i_r_data, line);
        cycle();
        bus.s_ready  = 1'b0;
        bus.s_r_data = '0;
        checkOutput("after_owner", 64'(bus.owner), 64'(0));
        checkOutput("after_s_r_en", 64'(bus.s_r_en), 64'(0));
        checkOutput("after_s_w_en", 64'(bus.s_w_en), 64'(0));
    endtask

    initial begin
        logic        dr;
        logic        dw;
        logic        ir;
        checks   = 0;
        errors   = 0;
        d_streak = 0;
        exp_err  = 1'b0;
        rst      = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
        bus.s_ready  = 1'b0;
        bus.s_r_data = '0;
        cycle();
        cycle();
        checkOutput("rst_owner", 64'(bus.owner), 64'(0));
        checkOutput("rst_s_r_en", 64'(bus.s_r_en), 64'(0));
        checkOutput("rst_s_w_en", 64'(bus.s_w_en), 64'(0));
        checkOutput("rst_s_addr", 64'(bus.s_addr), 64'(0));
        checkOutput("rst_s_w_data", 64'(bus.s_w_data), 64'(0));
        checkOutput("rst_proto_err", 64'(bus.proto_err), 64'(0));
        rst = 1'b0;
        cycle();

        $display("[TB] data read with five-cycle SRAM latency");
        run_txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b0, 32'h0, 4, 64'h1122_3344_5566_7788);

        $display("[TB] simultaneous data write and instruction read");
        run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0000_0080, 2, 64'h0);
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0080, 1, 64'hA5A5_0000_FFFF_1234);

        $display("[TB] starvation guard with both sides always requesting");
        for (int n = 0; n < 6; n++) begin
            run_txn(1'b1, 1'b0, 32'h0000_1000 + 32'(n * 64), 32'h0, 1'b1,
                    32'h0000_2000 + 32'(n * 64), n % 3, {32'(n), 32'h600D_F00D});
        end

        $display("[TB] data address change during ownership");
        run_txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b0, 32'h0, 3, 64'hCAFE_0000_0000_0400);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            dw = ($urandom_range(0, 2) == 0);
            dr = !dw && ($urandom_range(0, 3) != 0);
            ir = 1'($urandom);
            run_txn(dr, dw, $urandom, $urandom, ir, $urandom, $urandom_range(0, 4),
                    {$urandom, $urandom});
        end

        $display("[TB] data read and write enables together");
        run_txn(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, 32'h0, 1, 64'h0);
        run_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0, 0, 64'h7777_8888_9999_AAAA);
        checkOutput("err_sticky", 64'(bus.proto_err), 64'(1));

        $display("[TB] reset during instruction ownership");
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 64'h0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'h0000_0200);
        cycle();
        d_streak = 0;
        checkOutput("own_i_owner", 64'(bus.owner), 64'(2));
        checkOutput("own_i_s_r_en", 64'(bus.s_r_en), 64'(1));
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_s_r_en", 64'(bus.s_r_en), 64'(0));
        checkOutput("mid_rst_owner", 64'(bus.owner), 64'(0));
        checkOutput("mid_rst_i_ready", 64'(bus.i_ready), 64'(0));
        checkOutput("mid_rst_proto_err", 64'(bus.proto_err), 64'(0));
        cycle();
        rst      = 1'b0;
        exp_err  = 1'b0;
        d_streak = 0;
        bus.s_ready  = 1'b1;
        bus.s_r_data = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        checkOutput("stray_i_ready", 64'(bus.i_ready), 64'(0));
        checkOutput("stray_d_ready", 64'(bus.d_ready), 64'(0));
        cycle();
        bus.s_ready = 1'b0;
        checkOutput("stray_owner", 64'(bus.owner), 64'(0));
        checkOutput("stray_s_r_en", 64'(bus.s_r_en), 64'(0));
        run_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b1, 32'h0000_0304, 1, 64'h0123_4567_89AB_CDEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
